// File: rtl/serial_adder_if.sv
// Request/result bundle for the serial adder.
// The master issues operands; the slave returns status and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: STEP bits per clock through a ripple slice,
// result shifted in from the top and published on entry to DONE.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    logic [STEP-1:0]  bits;
    logic             ripple;
    logic             c_msb;
    logic             c_out;
    logic [WIDTH-1:0] acc_next;

    // STEP chained full-adder cells over the low bits of the operand shifters
    always_comb begin
        bits   = '0;
        ripple = c;
        c_msb  = c;
        for (int i = 0; i < STEP; i++) begin
            bits[i] = x[i] ^ y[i] ^ ripple;
            c_msb   = ripple;
            ripple  = (x[i] & y[i]) | (x[i] & ripple) | (y[i] & ripple);
        end
        c_out    = ripple;
        acc_next = (acc >> STEP) | (WIDTH'(bits) << (WIDTH - STEP));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            acc     <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        x      <= bus.a;
                        y      <= bus.sub ? ~bus.b : bus.b;
                        c      <= bus.sub ? 1'b1 : bus.cin;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x   <= x >> STEP;
                    y   <= y >> STEP;
                    c   <= c_out;
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= acc_next;
                        carry_q <= c_out;
                        ovf_q   <= c_msb ^ c_out;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
endmodule
